// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_resolve_unit: registered branch compare, redirect, link request and
// saturating branch/mispredict counters at the EX/MEM boundary.  Rev 1.0
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 32,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [7:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   target,
  input  logic              pred_taken,
  input  logic              clr_cnt,
  output logic              out_valid,
  output logic              taken,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              link_we,
  output logic [4:0]        link_addr,
  output logic [PC_W-1:0]   link_data,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mis_count
);

  localparam logic [7:0] c_op_beq    = 8'b0101_0001;
  localparam logic [7:0] c_op_bne    = 8'b0101_0010;
  localparam logic [7:0] c_op_blez   = 8'b0101_0011;
  localparam logic [7:0] c_op_bgtz   = 8'b0101_0100;
  localparam logic [7:0] c_op_bltz   = 8'b0100_0000;
  localparam logic [7:0] c_op_bgez   = 8'b0100_0001;
  localparam logic [7:0] c_op_bltzal = 8'b0100_1010;
  localparam logic [7:0] c_op_bgezal = 8'b0100_1011;

  logic              w_known, w_cond, w_link, w_capture;
  logic              w_rs_neg, w_rs_zero;
  logic [PC_W-1:0]   w_pc_plus8;

  logic              valid_q, valid_d;
  logic              taken_q, taken_d;
  logic              mis_q, mis_d;
  logic [PC_W-1:0]   redir_q, redir_d;
  logic              link_we_q, link_we_d;
  logic [PC_W-1:0]   link_data_q, link_data_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

  assign w_rs_neg   = rs_val[DATA_W-1];
  assign w_rs_zero  = (rs_val == '0);
  assign w_pc_plus8 = pc + PC_W'(8);

  always_comb begin
    w_known = 1'b1;
    w_cond  = 1'b0;
    w_link  = 1'b0;
    case (op)
      c_op_beq:    w_cond = (rs_val == rt_val);
      c_op_bne:    w_cond = (rs_val != rt_val);
      c_op_bgez:   w_cond = ~w_rs_neg;
      c_op_bltz:   w_cond = w_rs_neg;
      c_op_blez:   w_cond = w_rs_neg | w_rs_zero;
      c_op_bgtz:   w_cond = ~w_rs_neg & ~w_rs_zero;
      c_op_bgezal: begin w_cond = ~w_rs_neg; w_link = 1'b1; end
      c_op_bltzal: begin w_cond = w_rs_neg;  w_link = 1'b1; end
      default:     w_known = 1'b0;
    endcase
  end

  assign w_capture = in_valid & ~stall & ~flush & w_known;

  always_comb begin
    valid_d     = valid_q;
    taken_d     = taken_q;
    mis_d       = mis_q;
    redir_d     = redir_q;
    link_we_d   = link_we_q;
    link_data_d = link_data_q;
    br_cnt_d    = br_cnt_q;
    mis_cnt_d   = mis_cnt_q;

    // Flush beats stall; an idle edge drops the one-cycle qualifiers only.
    if (flush || (!stall && !w_capture)) begin
      valid_d   = 1'b0;
      link_we_d = 1'b0;
      mis_d     = 1'b0;
    end else if (w_capture) begin
      valid_d     = 1'b1;
      taken_d     = w_cond;
      mis_d       = w_cond ^ pred_taken;
      redir_d     = w_cond ? target : w_pc_plus8;
      link_we_d   = w_link;
      link_data_d = w_pc_plus8;
    end

    // Clear wins over a coincident capture; stall freezes the counters.
    if (!stall) begin
      if (clr_cnt) begin
        br_cnt_d  = '0;
        mis_cnt_d = '0;
      end else if (w_capture) begin
        if (!(&br_cnt_q))
          br_cnt_d = br_cnt_q + CNT_W'(1);
        if ((w_cond ^ pred_taken) && !(&mis_cnt_q))
          mis_cnt_d = mis_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q     <= 1'b0;
      taken_q     <= 1'b0;
      mis_q       <= 1'b0;
      redir_q     <= '0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      taken_q     <= taken_d;
      mis_q       <= mis_d;
      redir_q     <= redir_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign taken       = taken_q;
  assign mispredict  = mis_q;
  assign redirect_pc = redir_q;
  assign link_we     = link_we_q;
  assign link_addr   = 5'(LINK_REG);
  assign link_data   = link_data_q;
  assign br_count    = br_cnt_q;
  assign mis_count   = mis_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit: directed vectors, queue scoreboard and monitor.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int CNT_W = 3;

  localparam logic [7:0] c_op_beq    = 8'b0101_0001;
  localparam logic [7:0] c_op_bne    = 8'b0101_0010;
  localparam logic [7:0] c_op_blez   = 8'b0101_0011;
  localparam logic [7:0] c_op_bgtz   = 8'b0101_0100;
  localparam logic [7:0] c_op_bltz   = 8'b0100_0000;
  localparam logic [7:0] c_op_bgez   = 8'b0100_0001;
  localparam logic [7:0] c_op_bltzal = 8'b0100_1010;
  localparam logic [7:0] c_op_bgezal = 8'b0100_1011;

  logic              clk = 1'b0;
  logic              resetn, in_valid, stall, flush, pred_taken, clr_cnt;
  logic [7:0]        op;
  logic [31:0]       rs_val, rt_val, pc, target;
  logic              out_valid, taken, mispredict, link_we;
  logic [31:0]       redirect_pc, link_data;
  logic [4:0]        link_addr;
  logic [CNT_W-1:0]  br_count, mis_count;

  typedef struct packed {
    logic        taken;
    logic        mis;
    logic [31:0] redir;
    logic        lw;
    logic [31:0] ld;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  logic stall_at_edge = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  branch_resolve_unit #(.DATA_W(32), .PC_W(32), .CNT_W(CNT_W), .LINK_REG(31)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .stall(stall), .flush(flush),
    .op(op), .rs_val(rs_val), .rt_val(rt_val), .pc(pc), .target(target),
    .pred_taken(pred_taken), .clr_cnt(clr_cnt), .out_valid(out_valid), .taken(taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .link_we(link_we),
    .link_addr(link_addr), .link_data(link_data), .br_count(br_count), .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, ".taken"},       64'(taken),       64'(e.taken));
    chk({tag, ".mispredict"},  64'(mispredict),  64'(e.mis));
    chk({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(e.redir));
    chk({tag, ".link_we"},     64'(link_we),     64'(e.lw));
    chk({tag, ".link_data"},   64'(link_data),   64'(e.ld));
  endtask

  always @(posedge clk) stall_at_edge <= stall;

  // Fresh results are popped from the scoreboard; stalled edges must repeat the last one.
  always @(negedge clk) begin
    if (resetn && out_valid) begin
      if (stall_at_edge) begin
        cmp_out("held", last_exp);
      end else if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        last_exp = sb.pop_front();
        cmp_out("result", last_exp);
      end
    end
  end

  task automatic issue(input logic [7:0] o, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] p, input logic [31:0] t, input logic pr,
                       input logic clr, input logic push, input exp_t e);
    op = o; rs_val = rs; rt_val = rt; pc = p; target = t; pred_taken = pr;
    clr_cnt = clr; in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic idle_edge();
    @(posedge clk); #1;
  endtask

  task automatic chk_cnt(input string name, input int br, input int mis);
    chk({name, ".br_count"},  64'(br_count),  64'(br));
    chk({name, ".mis_count"}, 64'(mis_count), 64'(mis));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    op = 8'h00; rs_val = '0; rt_val = '0; pc = '0; target = '0; pred_taken = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst.out_valid",   64'(out_valid),   64'd0);
    chk("rst.taken",       64'(taken),       64'd0);
    chk("rst.mispredict",  64'(mispredict),  64'd0);
    chk("rst.link_we",     64'(link_we),     64'd0);
    chk("rst.redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst.link_data",   64'(link_data),   64'd0);
    chk("rst.link_addr",   64'(link_addr),   64'd31);
    chk_cnt("rst", 0, 0);
    @(posedge clk); #1 resetn = 1'b1;

    // Signed compares
    issue(c_op_bltz, 32'h8000_0000, 0, 32'h40, 32'h1000, 1'b0, 1'b0, 1'b1, '{1'b1, 1'b1, 32'h1000, 1'b0, 32'h48});
    issue(c_op_bgez, 32'h0,         0, 32'h50, 32'h2000, 1'b1, 1'b0, 1'b1, '{1'b1, 1'b0, 32'h2000, 1'b0, 32'h58});
    issue(c_op_bgtz, 32'h0,         0, 32'h60, 32'h3000, 1'b0, 1'b0, 1'b1, '{1'b0, 1'b0, 32'h68,   1'b0, 32'h68});
    issue(c_op_blez, 32'hFFFF_FFFF, 0, 32'h70, 32'h4000, 1'b1, 1'b0, 1'b1, '{1'b1, 1'b0, 32'h4000, 1'b0, 32'h78});
    idle_edge();
    chk("idle.out_valid", 64'(out_valid), 64'd0);
    chk("idle.taken_hold", 64'(taken), 64'd1);
    chk_cnt("signed", 4, 1);

    // Unrecognised op: no capture
    issue(8'h00, 32'h0, 32'h0, 32'h80, 32'h90, 1'b0, 1'b0, 1'b0, '0);
    chk("badop.out_valid", 64'(out_valid), 64'd0);
    chk_cnt("badop", 4, 1);

    // Redirect / mispredict / link
    issue(c_op_beq, 32'd5, 32'd5, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1, '{1'b1, 1'b1, 32'h200, 1'b0, 32'h108});
    issue(c_op_bne, 32'd5, 32'd5, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1, '{1'b0, 1'b0, 32'h108, 1'b0, 32'h108});
    issue(c_op_bltzal, 32'd1, 32'd0, 32'hFFFF_FFFC, 32'h500, 1'b0, 1'b0, 1'b1, '{1'b0, 1'b0, 32'h4, 1'b1, 32'h4});
    chk("link.link_addr", 64'(link_addr), 64'd31);
    issue(c_op_bgezal, 32'hFFFF_FFFF, 32'd0, 32'h10, 32'h900, 1'b1, 1'b0, 1'b1, '{1'b0, 1'b1, 32'h18, 1'b1, 32'h18});
    idle_edge();
    chk("idle2.link_we",   64'(link_we),     64'd0);
    chk("idle2.mispredict", 64'(mispredict), 64'd0);
    chk("idle2.redir_hold", 64'(redirect_pc), 64'h18);
    chk_cnt("link", 7, 3);

    // Clear, then stall/flush priority
    clr_cnt = 1'b1; idle_edge(); clr_cnt = 1'b0;
    chk_cnt("clr", 0, 0);
    issue(c_op_beq, 32'd7, 32'd7, 32'h300, 32'h340, 1'b1, 1'b0, 1'b1, '{1'b1, 1'b0, 32'h340, 1'b0, 32'h308});
    stall = 1'b1; in_valid = 1'b1; clr_cnt = 1'b1;
    op = c_op_bne; rs_val = 32'd7; rt_val = 32'd8; pc = 32'h400; target = 32'h500; pred_taken = 1'b0;
    repeat (3) idle_edge();
    chk("stall.out_valid", 64'(out_valid), 64'd1);
    chk_cnt("stall", 1, 0);
    clr_cnt = 1'b0; flush = 1'b1;
    idle_edge();
    chk("flush.out_valid",  64'(out_valid),  64'd0);
    chk("flush.mispredict", 64'(mispredict), 64'd0);
    chk("flush.taken_hold", 64'(taken),      64'd1);
    chk_cnt("flush", 1, 0);
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    idle_edge();
    chk("postflush.out_valid", 64'(out_valid), 64'd0);

    // Saturation
    repeat (9)
      issue(c_op_beq, 32'd0, 32'd0, 32'h600, 32'h700, 1'b0, 1'b0, 1'b1, '{1'b1, 1'b1, 32'h700, 1'b0, 32'h608});
    idle_edge();
    chk_cnt("sat", 7, 7);

    // Async reset mid-cycle while a result is presented
    issue(c_op_bne, 32'd1, 32'd2, 32'h800, 32'h900, 1'b1, 1'b0, 1'b1, '{1'b1, 1'b0, 32'h900, 1'b0, 32'h808});
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("arst.out_valid",   64'(out_valid),   64'd0);
    chk("arst.taken",       64'(taken),       64'd0);
    chk("arst.redirect_pc", 64'(redirect_pc), 64'd0);
    chk("arst.link_data",   64'(link_data),   64'd0);
    chk_cnt("arst", 0, 0);
    #1 resetn = 1'b1;
    idle_edge();
    chk("arst_rel.out_valid", 64'(out_valid), 64'd0);
    chk("arst_rel.link_addr", 64'(link_addr), 64'd31);

    // Clear coincident with a capture: clear wins
    issue(c_op_beq, 32'd3, 32'd3, 32'hA00, 32'hB00, 1'b0, 1'b1, 1'b1, '{1'b1, 1'b1, 32'hB00, 1'b0, 32'hA08});
    chk_cnt("clr_cap", 0, 0);
    idle_edge();
    idle_edge();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
